// File: rtl/reg_cmd_arbiter.sv
// Round-robin arbiter: N requesters share one parallel register through a single command port.
// Latency: grant is issued the cycle after req is sampled, and done follows one cycle later (3-cycle turnaround).
// Backpressure: req is held until gnt is seen; new requests are sampled only while IDLE.
//
// Ports:
//   clk, async_nreset        clock, asynchronous active-low reset
//   req[N], cmd[2N], wdata   per-requester request, command (NONE/LOAD/INCR/CLR) and load data
//   gnt[N], done, done_id    one-hot grant (ISSUE cycle), completion pulse and winner index (RESP cycle)
//   rdata, busy              register value after the operation (RESP), FSM not idle
//   reg_ctrl, reg_din        command and load data to the shared register (ISSUE only)
//   reg_dout                 current shared register value
module reg_cmd_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    input  logic [N-1:0]         req,
    input  logic [2*N-1:0]       cmd,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         gnt,
    output logic                 done,
    output logic [IW-1:0]        done_id,
    output logic [WIDTH-1:0]     rdata,
    output logic                 busy,
    output logic [1:0]           reg_ctrl,
    output logic [WIDTH-1:0]     reg_din,
    input  logic [WIDTH-1:0]     reg_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [IW:0]   N_W  = (IW + 1)'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IW-1:0]      ptr;        // first index searched on the next arbitration
    logic [IW-1:0]      win_q;
    logic [1:0]         cmd_q;
    logic [WIDTH-1:0]   wdata_q;

    logic [IW:0]        cand;
    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic               accept;

    // Rotating priority search starting at ptr; the index sum is reduced
    // modulo N explicitly so non-power-of-two N wraps correctly.
    always_comb begin
        cand    = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!win_vld && req[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && win_vld;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state   <= IDLE;
            ptr     <= '0;
            win_q   <= '0;
            cmd_q   <= 2'b00;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            // Operands are captured once at acceptance so later input
            // changes cannot disturb the transaction in flight.
            if (accept) begin
                win_q   <= win_idx;
                cmd_q   <= cmd[2*win_idx +: 2];
                wdata_q <= wdata[WIDTH*win_idx +: WIDTH];
                ptr     <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // Outputs decode only registered state, so reset clears them at once.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = 1'b0;
        done_id   = '0;
        rdata     = '0;
        busy      = (state != IDLE);
        reg_ctrl  = 2'b00;
        reg_din   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt[win_q] = 1'b1;
                reg_ctrl   = cmd_q;
                reg_din    = wdata_q;
                state_nxt  = RESP;
            end
            RESP: begin
                done      = 1'b1;
                done_id   = win_q;
                rdata     = reg_dout;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_arbiter.sv
module tb_reg_cmd_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic               clk;
    logic               async_nreset;
    logic [N-1:0]       req;
    logic [2*N-1:0]     cmd;
    logic [N*W-1:0]     wdata;
    logic [N-1:0]       gnt;
    logic               done;
    logic [IW-1:0]      done_id;
    logic [W-1:0]       rdata;
    logic               busy;
    logic [1:0]         reg_ctrl;
    logic [W-1:0]       reg_din;
    logic [W-1:0]       reg_dout;

    logic               ext_rst_n;
    logic [W-1:0]       ext_reg;

    int n_checks;
    int n_pass;

    // Reference state: shared register contents and next search start.
    logic [W-1:0] m_reg;
    int           m_ptr;

    reg_cmd_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .req          (req),
        .cmd          (cmd),
        .wdata        (wdata),
        .gnt          (gnt),
        .done         (done),
        .done_id      (done_id),
        .rdata        (rdata),
        .busy         (busy),
        .reg_ctrl     (reg_ctrl),
        .reg_din      (reg_din),
        .reg_dout     (reg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared parallel register sitting behind the arbiter.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            ext_reg <= '0;
        end else begin
            case (reg_ctrl)
                2'd1:    ext_reg <= reg_din;
                2'd2:    ext_reg <= ext_reg + 1'b1;
                2'd3:    ext_reg <= '0;
                default: ext_reg <= ext_reg;
            endcase
        end
    end
    assign reg_dout = ext_reg;

    // One full transaction: drive at a quiet point in IDLE, then check the
    // ISSUE, RESP and following IDLE cycles against the reference model.
    task automatic do_txn(input string name, input logic [N-1:0] r, input logic [2*N-1:0] c,
                          input logic [N*W-1:0] w, input bit late, input int exp_win, input int exp_rd);
        int           win;
        int           idx;
        logic [1:0]   op;
        logic [W-1:0] d;
        logic [W-1:0] expv;
        logic [N-1:0] exp_gnt;
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && r[idx]) win = idx;
        end
        if (win < 0) win = 0;
        op = c[2*win +: 2];
        d  = w[W*win +: W];
        case (op)
            2'd0:    expv = m_reg;
            2'd1:    expv = d;
            2'd2:    expv = m_reg + 1'b1;
            default: expv = '0;
        endcase
        exp_gnt = '0;
        exp_gnt[win] = 1'b1;

        req = r; cmd = c; wdata = w;
        @(posedge clk); #1;
        n_checks++; if (gnt !== exp_gnt) $display("FAIL %s gnt: got %b want %b", name, gnt, exp_gnt); else n_pass++;
        if (exp_win >= 0) begin
            n_checks++; if (gnt[exp_win] !== 1'b1) $display("FAIL %s directed_winner: gnt %b want bit %0d", name, gnt, exp_win); else n_pass++;
        end
        n_checks++; if (reg_ctrl !== op) $display("FAIL %s reg_ctrl: got %0d want %0d", name, reg_ctrl, op); else n_pass++;
        n_checks++; if (reg_din !== d) $display("FAIL %s reg_din: got %h want %h", name, reg_din, d); else n_pass++;
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL %s issue_flags: done %b busy %b want 0 1", name, done, busy); else n_pass++;

        req[win] = 1'b0;
        if (late) begin
            cmd   = {N{2'b11}};
            wdata = (N*W)'($urandom);
        end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1) $display("FAIL %s done: got %b want 1", name, done); else n_pass++;
        n_checks++; if (int'(done_id) !== win) $display("FAIL %s done_id: got %0d want %0d", name, done_id, win); else n_pass++;
        n_checks++; if (rdata !== expv) $display("FAIL %s rdata: got %h want %h", name, rdata, expv); else n_pass++;
        if (exp_rd >= 0) begin
            n_checks++; if (int'(rdata) !== exp_rd) $display("FAIL %s directed_rdata: got %h want %h", name, rdata, exp_rd); else n_pass++;
        end
        n_checks++; if (gnt !== '0 || reg_ctrl !== 2'd0 || reg_din !== '0 || busy !== 1'b1)
            $display("FAIL %s resp_quiet: gnt %b ctrl %0d din %h busy %b want 0 0 0 1", name, gnt, reg_ctrl, reg_din, busy);
        else n_pass++;
        m_reg = expv;
        m_ptr = (win + 1) % N;

        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== '0 || done_id !== '0 || gnt !== '0)
            $display("FAIL %s idle_after: done %b busy %b rdata %h id %0d gnt %b want all 0", name, done, busy, rdata, done_id, gnt);
        else n_pass++;
        req = '0;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (gnt !== '0 || done !== 1'b0 || done_id !== '0 || rdata !== '0 || busy !== 1'b0 || reg_ctrl !== 2'd0 || reg_din !== '0)
            $display("FAIL %s outputs: gnt %b done %b id %0d rdata %h busy %b ctrl %0d din %h want all 0",
                     name, gnt, done, done_id, rdata, busy, reg_ctrl, reg_din);
        else n_pass++;
    endtask

    task automatic test_reset();
        async_nreset = 1'b0;
        ext_rst_n = 1'b0;
        req = '0; cmd = '0; wdata = '0;
        #1;
        check_all_zero("reset_immediate");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        ext_rst_n = 1'b1;
        async_nreset = 1'b1;
        m_reg = '0;
        m_ptr = 0;
    endtask

    task automatic test_no_req();
        // A request raised and dropped between edges must never be granted.
        for (int i = 0; i < 3; i++) begin
            req = 4'b1000;
            #2;
            req = '0;
            @(posedge clk); #1;
            check_all_zero("no_req_idle");
        end
    endtask

    task automatic test_single_load();
        do_txn("single_load", 4'b0100, 8'b00_01_00_00, 32'h00A5_0000, 1'b0, 2, 8'hA5);
    endtask

    task automatic test_round_robin();
        // CLR from requester 3 zeroes the register and points the search at 0.
        do_txn("rr_setup", 4'b1000, {N{2'b11}}, '0, 1'b0, 3, 0);
        for (int i = 0; i < 5; i++) begin
            do_txn("round_robin", 4'b1111, {N{2'b10}}, '0, 1'b0, i % N, i + 1);
        end
    endtask

    task automatic test_wrap();
        do_txn("wrap_setup", 4'b1000, {N{2'b00}}, '0, 1'b0, 3, -1);
        do_txn("wrap_first", 4'b1001, {N{2'b00}}, '0, 1'b0, 0, -1);
        do_txn("wrap_second", 4'b1001, {N{2'b00}}, '0, 1'b0, 3, -1);
    endtask

    task automatic test_clr_read();
        do_txn("clr_load", 4'b0010, 8'b00_00_01_00, 32'h0000_3C00, 1'b0, 1, 8'h3C);
        do_txn("clr_clr", 4'b0010, 8'b00_00_11_00, '0, 1'b0, 1, 0);
        do_txn("clr_read", 4'b0010, 8'b00_00_00_00, '0, 1'b0, 1, 0);
    endtask

    task automatic test_late_change();
        do_txn("late_change", 4'b0010, 8'b00_00_01_00, 32'h0000_5A00, 1'b1, 1, 8'h5A);
    endtask

    task automatic test_midop_reset();
        req = 4'b0100; cmd = 8'b00_01_00_00; wdata = 32'h0077_0000;
        @(posedge clk); #1;
        n_checks++; if (gnt !== 4'b0100) $display("FAIL midop_issue gnt: got %b want 0100", gnt); else n_pass++;
        async_nreset = 1'b0;
        #1;
        check_all_zero("midop_reset_immediate");
        req = '0;
        @(posedge clk); #1;
        check_all_zero("midop_reset_held");
        m_ptr = 0;
        async_nreset = 1'b1;
        do_txn("midop_after", 4'b0010, {N{2'b00}}, '0, 1'b0, 1, -1);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        for (int t = 0; t < 40; t++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            do_txn("random", r, (2*N)'($urandom), (N*W)'($urandom), 1'($urandom), -1, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_no_req();
        test_single_load();
        test_round_robin();
        test_wrap();
        test_clr_read();
        test_late_change();
        test_midop_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_cmd_arbiter.md
REG_CMD_ARBITER -- requirements
Module: reg_cmd_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of the shared register.
REQ-002 Parameter N, default 4: number of requesters.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 async_nreset  input  1  reset; asynchronous, active-low.
REQ-005 req  input  N  per-requester request; bit i held high until gnt[i] is seen.
REQ-006 cmd  input  2N  per-requester command, bits [2i+1:2i]: 0 NONE (read), 1 LOAD, 2 INCR, 3 CLR.
REQ-007 wdata  input  N*WIDTH  per-requester load data, bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008 gnt  output  N  one-hot grant; registered; high for exactly one cycle per accepted request.
REQ-009 done  output  1  operation-complete pulse; one cycle per accepted request.
REQ-010 done_id  output  log2(N) (min 1)  index of the requester whose operation completes; valid while done=1, else 0.
REQ-011 rdata  output  WIDTH  register value after the operation; valid while done=1, else 0.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 reg_ctrl  output  2  command to the shared parallel register, same encoding as cmd.
REQ-014 reg_din  output  WIDTH  load data to the shared register.
REQ-015 reg_dout  input  WIDTH  current value of the shared register.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; IDLE->ISSUE when |req=1, else stay; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-017 On the IDLE->ISSUE edge the winner index, its cmd and its wdata are latched; gnt[winner]=1 during the ISSUE cycle only.
REQ-018 Arbitration round-robin: search starts at (last_winner+1) mod N, wrapping; lowest index after the pointer wins.
REQ-019 last_winner updates only on acceptance; after reset the search starts at requester 0.
REQ-020 In ISSUE: reg_ctrl = latched cmd, reg_din = latched wdata, for exactly one cycle.
REQ-021 In IDLE and RESP: reg_ctrl = NONE (0), reg_din = 0.
REQ-022 In RESP: done=1, done_id = latched winner, rdata = reg_dout (value after the issued command).
REQ-023 Latency: req sampled at edge k -> gnt during cycle k..k+1 -> done during cycle k+1..k+2; maximum throughput one operation per 3 cycles.
REQ-024 A cmd of NONE is a legal read: register unchanged, rdata returns current value.
REQ-025 req/cmd/wdata changes after acceptance have no effect on the operation in flight; a req dropped while IDLE before acceptance is never granted.
REQ-026 A req still high in RESP (a new transaction) is arbitrated in the next IDLE cycle under normal round-robin.
REQ-027 Only one register command is issued per transaction; no two requesters are ever granted in the same cycle.

Reset
REQ-028 async_nreset=0 immediately forces: state IDLE, gnt=0, done=0, done_id=0, rdata=0, busy=0, reg_ctrl=NONE, reg_din=0, pointer to requester 0.
REQ-029 Reset asserted during ISSUE or RESP aborts the operation; no done is produced for it after release.
REQ-030 The first arbitration after reset release occurs at the first rising edge with async_nreset=1.

Verification
REQ-031 Single LOAD: req[2]=1, cmd=LOAD, wdata[2]=0xA5 -> gnt=0b0100 for 1 cycle, reg_ctrl=1 with reg_din=0xA5 for 1 cycle, next cycle done=1, done_id=2, rdata=0xA5.
REQ-032 Round-robin fairness: req=0b1111 held, all INCR, register starting at 0 -> grants 0,1,2,3,0 in order; rdata 1,2,3,4,5.
REQ-033 Wrap and pointer: last winner 3, req=0b1001 -> requester 0 granted, then requester 3.
REQ-034 CLR then read: register 0x3C, CLR from requester 1 then NONE from requester 1 -> rdata 0x00 both times, register holds 0x00.
REQ-035 Mid-op reset: assert async_nreset=0 during ISSUE -> all outputs 0/NONE immediately; after release with req=0b0010 -> requester 1 granted, no stale done.
REQ-036 Late change: cmd[1:0] changed from LOAD to CLR during gnt cycle -> LOAD executed, rdata = loaded value.
